// File: rtl/pic_pkg.sv
// Shared types and the rotating priority search for the PIC acknowledge path.
// The rotation variant is enabled with PIC_ROTATE_EN.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef enum logic [1:0] {IDLE, ACK1, VEC} pic_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] lvl;
  } prio_t;

  // Highest priority slot is ptr+1; scanning from the lowest slot lets the last hit win.
  function automatic prio_t prio_first(input logic [NUM_IR-1:0] v, input logic [2:0] ptr);
    prio_t      r;
    logic [2:0] idx;
    r = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = ptr + 3'd1 + 3'(i);
      if (v[idx]) begin
        r.found = 1'b1;
        r.lvl   = idx;
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_IR-1:0] lvl2oh(input logic [2:0] l);
    return NUM_IR'(1) << l;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational priority resolver: highest-priority set bit and its rank
// relative to the rotation pointer (rank 0 = highest priority).
module pic_prio_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec_i,
  input  logic [2:0]        ptr_i,
  output logic              found_o,
  output logic [2:0]        lvl_o,
  output logic [2:0]        rank_o
);

  prio_t res;

  always_comb begin
    res = prio_first(vec_i, ptr_i);
  end

  assign found_o = res.found;
  assign lvl_o   = res.lvl;
  assign rank_o  = res.lvl - ptr_i - 3'd1;

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259-style INTA sequencer and in-service tracker with EOI/AEOI handling.
// Define PIC_ROTATE_EN for automatic priority rotation; default is fixed IR0-highest.
module pic_ack_sequencer
  import pic_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_IR-1:0] irr_i,
  input  logic [NUM_IR-1:0] mask_i,
  input  logic              inta_i,
  input  logic [4:0]        vec_base_i,
  input  logic              aeoi_i,
  input  logic              eoi_cmd_i,
  input  logic              eoi_specific_i,
  input  logic [2:0]        eoi_level_i,
  output logic              int_o,
  output logic [NUM_IR-1:0] isr_o,
  output logic [NUM_IR-1:0] clr_irr_o,
  output logic [7:0]        vec_out_o,
  output logic              vec_oe_o,
  output logic              ack_done_o
);

  pic_state_e        state_q;
  logic              inta_q, spur_q, int_q, vec_oe_q, ack_done_q;
  logic [2:0]        lvl_q;
  logic [NUM_IR-1:0] isr_q, isr_d, clr_irr_q;
  logic [7:0]        vec_out_q;
  logic [2:0]        ptr;

`ifdef PIC_ROTATE_EN
  logic [2:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 3'd7;
`endif

  logic [NUM_IR-1:0] pend;
  logic              pend_found, isr_found;
  logic [2:0]        pend_lvl, pend_rank, isr_lvl, isr_rank;

  assign pend = irr_i & ~mask_i;

  pic_prio_resolver u_pend_res (
    .vec_i(pend), .ptr_i(ptr), .found_o(pend_found), .lvl_o(pend_lvl), .rank_o(pend_rank)
  );

  pic_prio_resolver u_isr_res (
    .vec_i(isr_q), .ptr_i(ptr), .found_o(isr_found), .lvl_o(isr_lvl), .rank_o(isr_rank)
  );

  logic              rise, valid, ack_start, ack_end;
  logic [NUM_IR-1:0] set_vec, eoi_clr, aeoi_clr;

  assign rise      = inta_i & ~inta_q;
  assign valid     = pend_found & (~isr_found | (pend_rank < isr_rank));
  assign ack_start = (state_q == IDLE) & rise;
  assign ack_end   = (state_q == VEC) & ~inta_i;

  // Clears apply before the set so a bit being acknowledged this cycle survives an EOI.
  always_comb begin
    set_vec  = '0;
    eoi_clr  = '0;
    aeoi_clr = '0;
    if (ack_start && pend_found) set_vec = lvl2oh(pend_lvl);
    if (eoi_cmd_i) begin
      if (eoi_specific_i)  eoi_clr = lvl2oh(eoi_level_i);
      else if (isr_found)  eoi_clr = lvl2oh(isr_lvl);
    end
    if (ack_end && aeoi_i && !spur_q) aeoi_clr = lvl2oh(lvl_q);
    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | set_vec;
  end

`ifdef PIC_ROTATE_EN
  always_comb begin
    ptr_d = ptr_q;
    if (ack_end && aeoi_i && !spur_q) ptr_d = lvl_q;
    if (eoi_cmd_i && !eoi_specific_i && isr_found) ptr_d = isr_lvl;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      inta_q     <= 1'b0;
      spur_q     <= 1'b0;
      lvl_q      <= 3'd0;
      isr_q      <= '0;
      int_q      <= 1'b0;
      clr_irr_q  <= '0;
      vec_out_q  <= 8'h00;
      vec_oe_q   <= 1'b0;
      ack_done_q <= 1'b0;
`ifdef PIC_ROTATE_EN
      ptr_q      <= 3'd7;
`endif
    end else begin
      inta_q     <= inta_i;
      isr_q      <= isr_d;
      clr_irr_q  <= set_vec;
      int_q      <= 1'b0;
      ack_done_q <= 1'b0;
`ifdef PIC_ROTATE_EN
      ptr_q      <= ptr_d;
`endif
      case (state_q)
        IDLE: begin
          int_q <= valid & ~rise;
          if (rise) begin
            lvl_q   <= pend_found ? pend_lvl : 3'd7;
            spur_q  <= ~pend_found;
            state_q <= ACK1;
          end
        end
        ACK1: begin
          if (rise) begin
            state_q   <= VEC;
            vec_oe_q  <= 1'b1;
            vec_out_q <= {vec_base_i, lvl_q};
          end
        end
        VEC: begin
          vec_out_q <= {vec_base_i, lvl_q};
          if (!inta_i) begin
            state_q    <= IDLE;
            vec_oe_q   <= 1'b0;
            vec_out_q  <= 8'h00;
            ack_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign int_o      = int_q;
  assign isr_o      = isr_q;
  assign clr_irr_o  = clr_irr_q;
  assign vec_out_o  = vec_out_q;
  assign vec_oe_o   = vec_oe_q;
  assign ack_done_o = ack_done_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Bench for pic_ack_sequencer: directed scenarios plus randomized acknowledge/EOI
// traffic against a priority-rule model. Honors PIC_ROTATE_EN like the design.
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset, inta, aeoi, eoi_cmd, eoi_spec;
  logic [7:0] irr, msk;
  logic [4:0] vbase;
  logic [2:0] eoi_lvl;
  logic       int_s, vec_oe, ack_done;
  logic [7:0] isr, clr_irr, vec_out;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_isr;
  int         m_ptr;

`ifdef PIC_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  always #5 clk = ~clk;

  pic_ack_sequencer dut (
    .clk_i(clk), .reset_i(reset), .irr_i(irr), .mask_i(msk), .inta_i(inta),
    .vec_base_i(vbase), .aeoi_i(aeoi), .eoi_cmd_i(eoi_cmd), .eoi_specific_i(eoi_spec),
    .eoi_level_i(eoi_lvl), .int_o(int_s), .isr_o(isr), .clr_irr_o(clr_irr),
    .vec_out_o(vec_out), .vec_oe_o(vec_oe), .ack_done_o(ack_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: walk priority slots starting just after the lowest-priority pointer.
  function automatic int m_first(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++)
      if (v[(p + 1 + k) % 8]) return (p + 1 + k) % 8;
    return -1;
  endfunction

  function automatic int m_rank(input int l, input int p);
    return (l - p + 15) % 8;
  endfunction

  function automatic logic m_valid(input logic [7:0] pend);
    if (pend == 8'h00) return 1'b0;
    if (m_isr == 8'h00) return 1'b1;
    return m_rank(m_first(pend, m_ptr), m_ptr) < m_rank(m_first(m_isr, m_ptr), m_ptr);
  endfunction

  task automatic set_req(input logic [7:0] r, input logic [7:0] m, output logic got);
    logic exp;
    irr = r; msk = m;
    exp = m_valid(r & ~m);
    tick;
    checks++;
    if (int_s !== exp) begin
      errors++;
      $display("FAIL int_level: got %b want %b (irr %h mask %h isr %h)", int_s, exp, r, m, m_isr);
    end
    got = int_s;
  endtask

  task automatic do_eoi(input logic sp, input logic [2:0] l);
    int hl;
    eoi_cmd = 1'b1; eoi_spec = sp; eoi_lvl = l;
    tick;
    eoi_cmd = 1'b0;
    if (sp) m_isr = m_isr & ~(8'h01 << l);
    else if (m_isr != 8'h00) begin
      hl = m_first(m_isr, m_ptr);
      m_isr[hl] = 1'b0;
      if (ROT) m_ptr = hl;
    end
    checks++;
    if (isr !== m_isr) begin
      errors++;
      $display("FAIL eoi_isr: got %h want %h (specific %b level %0d)", isr, m_isr, sp, l);
    end
  endtask

  task automatic do_ack(input logic [7:0] r, input logic [7:0] m, input logic [4:0] b,
                        input logic a, input logic ce, input logic [2:0] cl,
                        output logic [7:0] got_vec);
    logic [7:0] pend, set_m, clr_m, exp_vec;
    logic       sp;
    logic [2:0] lv;
    pend    = r & ~m;
    sp      = (pend == 8'h00);
    lv      = sp ? 3'd7 : 3'(m_first(pend, m_ptr));
    set_m   = sp ? 8'h00 : (8'h01 << lv);
    clr_m   = ce ? (8'h01 << cl) : 8'h00;
    exp_vec = {b, lv};
    irr = r; msk = m; vbase = b; aeoi = a;
    inta = 1'b1; eoi_cmd = ce; eoi_spec = 1'b1; eoi_lvl = cl;
    tick;
    inta = 1'b0; eoi_cmd = 1'b0;
    m_isr = (m_isr & ~clr_m) | set_m;
    checks++;
    if (int_s !== 1'b0) begin errors++; $display("FAIL ack1_int: got %b want 0", int_s); end
    checks++;
    if (clr_irr !== set_m) begin errors++; $display("FAIL ack1_clr_irr: got %h want %h", clr_irr, set_m); end
    checks++;
    if (isr !== m_isr) begin errors++; $display("FAIL ack1_isr: got %h want %h", isr, m_isr); end
    repeat (1 + $urandom_range(1)) begin
      tick;
      checks++;
      if ({clr_irr, vec_oe} !== 9'h000) begin
        errors++; $display("FAIL ack_gap: got clr_irr %h vec_oe %b want 00/0", clr_irr, vec_oe);
      end
    end
    inta = 1'b1;
    tick;
    got_vec = vec_out;
    checks++;
    if (vec_oe !== 1'b1) begin errors++; $display("FAIL vec_oe_rise: got %b want 1", vec_oe); end
    checks++;
    if (vec_out !== exp_vec) begin errors++; $display("FAIL vec_out: got %h want %h", vec_out, exp_vec); end
    repeat ($urandom_range(2)) begin
      tick;
      checks++;
      if (vec_oe !== 1'b1) begin errors++; $display("FAIL vec_oe_hold: got %b want 1", vec_oe); end
    end
    inta = 1'b0;
    tick;
    if (a && !sp) begin
      m_isr = m_isr & ~set_m;
      if (ROT) m_ptr = lv;
    end
    checks++;
    if ({vec_oe, ack_done} !== 2'b01) begin
      errors++; $display("FAIL ack_end: got vec_oe %b ack_done %b want 0/1", vec_oe, ack_done);
    end
    checks++;
    if (isr !== m_isr) begin errors++; $display("FAIL ack_end_isr: got %h want %h", isr, m_isr); end
    tick;
    checks++;
    if (ack_done !== 1'b0) begin errors++; $display("FAIL ack_done_pulse: got %b want 0", ack_done); end
  endtask

  task automatic test_reset;
    reset = 1'b1; inta = 1'b0; aeoi = 1'b0; eoi_cmd = 1'b0; eoi_spec = 1'b0;
    irr = 8'h00; msk = 8'h00; vbase = 5'h00; eoi_lvl = 3'd0;
    m_isr = 8'h00; m_ptr = 7;
    tick; tick;
    checks++;
    if ({int_s, isr, clr_irr, vec_out, vec_oe, ack_done} !== 27'h0) begin
      errors++;
      $display("FAIL reset_state: got int %b isr %h clr %h vec %h oe %b done %b want all 0",
               int_s, isr, clr_irr, vec_out, vec_oe, ack_done);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic       got;
    logic [7:0] gv;
    set_req(8'h24, 8'h00, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL plan_int_rise: got %b want 1", got); end
    do_ack(8'h24, 8'h00, 5'h08, 1'b0, 1'b0, 3'd0, gv);
    checks++;
    if (gv !== 8'h42) begin errors++; $display("FAIL plan_vec42: got %h want 42", gv); end
    checks++;
    if (isr !== 8'h04) begin errors++; $display("FAIL plan_isr04: got %h want 04", isr); end
    set_req(8'h01, 8'h00, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL plan_nest_int: got %b want 1", got); end
    set_req(8'h08, 8'h00, got);
    checks++;
    if (got !== 1'b0) begin errors++; $display("FAIL plan_lower_int: got %b want 0", got); end
    set_req(8'h00, 8'h00, got);
    do_ack(8'h00, 8'h00, 5'h08, 1'b0, 1'b0, 3'd0, gv);
    checks++;
    if ({gv, isr} !== 16'h4704) begin errors++; $display("FAIL plan_spurious: got vec %h isr %h want 47/04", gv, isr); end
    set_req(8'h02, 8'h00, got);
    do_ack(8'h02, 8'h00, 5'h08, 1'b0, 1'b0, 3'd0, gv);
    do_eoi(1'b0, 3'd0);
    checks++;
    if (isr !== 8'h04) begin errors++; $display("FAIL plan_nseoi: got %h want 04", isr); end
    do_eoi(1'b1, 3'd2);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL plan_seoi: got %h want 00", isr); end
    set_req(8'h20, 8'h00, got);
    do_ack(8'h20, 8'h00, 5'h08, 1'b1, 1'b0, 3'd0, gv);
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL plan_aeoi: got %h want 00", isr); end
    aeoi = 1'b0;
  endtask

  task automatic test_reset_mid_ack;
    irr = 8'h10; msk = 8'h00; vbase = 5'h1f;
    tick;
    inta = 1'b1; tick;
    inta = 1'b0; tick;
    inta = 1'b1; tick;
    checks++;
    if (vec_oe !== 1'b1) begin errors++; $display("FAIL mid_in_vec: got %b want 1", vec_oe); end
    reset = 1'b1;
    tick;
    checks++;
    if ({int_s, isr, clr_irr, vec_out, vec_oe, ack_done} !== 27'h0) begin
      errors++;
      $display("FAIL mid_reset: got int %b isr %h clr %h vec %h oe %b done %b want all 0",
               int_s, isr, clr_irr, vec_out, vec_oe, ack_done);
    end
    reset = 1'b0; inta = 1'b0; irr = 8'h00;
    m_isr = 8'h00; m_ptr = 7;
    tick;
  endtask

  task automatic test_rotate;
    logic       got;
    logic [7:0] gv;
    logic [2:0] exp_lvl;
    exp_lvl = ROT ? 3'd7 : 3'd0;
    set_req(8'h01, 8'h00, got);
    do_ack(8'h01, 8'h00, 5'h08, 1'b0, 1'b0, 3'd0, gv);
    do_eoi(1'b0, 3'd0);
    set_req(8'h81, 8'h00, got);
    do_ack(8'h81, 8'h00, 5'h08, 1'b0, 1'b0, 3'd0, gv);
    checks++;
    if (gv[2:0] !== exp_lvl) begin errors++; $display("FAIL rotate_level: got %0d want %0d", gv[2:0], exp_lvl); end
  endtask

  task automatic test_random;
    logic       got, ce;
    logic [7:0] r, m, gv;
    int         op;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(3);
      if (op == 3) begin
        do_eoi(1'($urandom_range(1)), 3'($urandom_range(7)));
      end else begin
        r = 8'($urandom);
        m = ($urandom_range(1) == 1) ? 8'h00 : 8'($urandom);
        if ($urandom_range(4) == 0) r = 8'h00;
        set_req(r, m, got);
        if (m_valid(r & ~m) || ((r & ~m) == 8'h00)) begin
          ce = ($urandom_range(3) == 0);
          do_ack(r, m, 5'($urandom), 1'($urandom_range(1)), ce, 3'($urandom_range(7)), gv);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_mid_ack;
    test_rotate;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
